varredor_teclado: RTL and testbench

Scanned 4x4 keypad reader for the irrigation controller front panel. It is the input-direction counterpart of the multiplexed 7-segment display driver. It drives one-cold column strobes, samples active-low row lines, and debounces the result over whole scans. It reports a single valid key as a 4-bit code with a one-cycle strobe plus a held level, for the mode/threshold logic that feeds the display.

---
 rtl/varredor_teclado_pkg.sv | 65 ++++++
 rtl/varredor_teclado_varre_coluna.sv | 44 ++++
 rtl/varredor_teclado.sv | 191 +++++++++++++++++++
 tb/tb_varredor_teclado.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/varredor_teclado_pkg.sv
// -----------------------------------------------------------------------------
// varredor_teclado_pkg
// Shared definitions for the scanned 4x4 keypad reader:
//   - state_t        : debounce FSM states
//   - scan_result_t  : per-scan classification (valid code / NONE / MULTI)
//   - key-code field positions: column in [3:2], row in [1:0]
//   - classify()     : one-hot / popcount check over the 16 hit bits
// -----------------------------------------------------------------------------
package varredor_teclado_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  // Key-code field positions.
  localparam int CODE_COL_HI = 3;
  localparam int CODE_COL_LO = 2;
  localparam int CODE_ROW_HI = 1;
  localparam int CODE_ROW_LO = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // valid=1           : exactly one key, code is meaningful
  // valid=0, multi=0  : NONE
  // valid=0, multi=1  : MULTI (ghosting or multi-press)
  typedef struct packed {
    logic       valid;
    logic       multi;
    logic [3:0] code;
  } scan_result_t;

  function automatic logic [3:0] make_code(input logic [1:0] col,
                                           input logic [1:0] row);
    logic [3:0] c;
    c = '0;
    c[CODE_COL_HI:CODE_COL_LO] = col;
    c[CODE_ROW_HI:CODE_ROW_LO] = row;
    return c;
  endfunction

  // Hit bit index is col*4+row, which is exactly the key-code layout, so the
  // position of the single set bit is the code itself.
  function automatic scan_result_t classify(input logic [15:0] hits);
    scan_result_t r;
    r = '{valid: 1'b0, multi: 1'b0, code: 4'h0};
    for (int i = 0; i < NUM_COLS * NUM_ROWS; i++) begin
      if (hits[i]) begin
        if (r.valid || r.multi) begin
          r.valid = 1'b0;
          r.multi = 1'b1;
        end else begin
          r.valid = 1'b1;
          r.code  = 4'(i);
        end
      end
    end
    if (r.multi) r.code = 4'h0;
    return r;
  endfunction

endpackage

// File: rtl/varredor_teclado_varre_coluna.sv
// -----------------------------------------------------------------------------
// varre_coluna
// Column scanner: dwell counter plus mod-4 column index, same counting scheme
// as the display digit selector.
//   clk, rst     : clock, synchronous active-high reset
//   col_n[3:0]   : one-cold column strobe, ~(1 << col_idx)
//   col_idx[1:0] : current column
//   last_dwell   : high on the final dwell cycle of the current column
// -----------------------------------------------------------------------------
module varre_coluna
  import varredor_teclado_pkg::*;
#(
  parameter int DWELL = 256
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_n,
  output logic [1:0] col_idx,
  output logic       last_dwell
);

  localparam int DW_W = $clog2(DWELL);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0] dwell_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
    end else if (last_dwell) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;  // wraps 3 -> 0
    end else begin
      dwell_cnt <= dwell_cnt + DW_W'(1);
    end
  end

  assign last_dwell = (dwell_cnt == DWELL_LAST);
  assign col_n      = ~(4'b0001 << col_idx);

endmodule

// File: rtl/varredor_teclado.sv
// -----------------------------------------------------------------------------
// varredor_teclado
// Scanned 4x4 keypad reader with whole-scan debounce.
//   clk            : system clock
//   rst            : synchronous active-high reset
//   row_n[3:0]     : keypad rows, active-low, asynchronous
//   col_n[3:0]     : column strobes, active-low, exactly one low
//   key_code[3:0]  : {column, row} of the last accepted key
//   key_valid      : one-cycle pulse on press acceptance
//   key_held       : high from press acceptance to release acceptance
// -----------------------------------------------------------------------------
module varredor_teclado
  import varredor_teclado_pkg::*;
#(
  parameter int DWELL    = 256,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);

  // ---------------------------------------------------------------- scanner
  logic [1:0] col_idx;
  logic       last_dwell;

  varre_coluna #(.DWELL(DWELL)) u_varre_coluna (
    .clk        (clk),
    .rst        (rst),
    .col_n      (col_n),
    .col_idx    (col_idx),
    .last_dwell (last_dwell)
  );

  // ----------------------------------------------------------- synchroniser
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // --------------------------------------------------------------- sampling
  logic [15:0] hit_q;
  logic        scan_end;
  logic [15:0] hits_now;

  // NOTE: the hit vectors are plain flops rather than a RAM, so they are reset;
  // this keeps a stale hit from a previous run out of the first scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= '0;
    end else if (last_dwell) begin
      hit_q[{col_idx, 2'b00} +: 4] <= ~row_sync;
    end
  end

  assign scan_end = last_dwell && (col_idx == 2'd3);

  // Column 3 is sampled on the same cycle the scan is evaluated, so its hit
  // vector is taken straight from the synchroniser instead of the register.
  assign hits_now = {~row_sync, hit_q[11:0]};

  scan_result_t result;
  assign result = classify(hits_now);

  // ----------------------------------------------------------- debounce FSM
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]       cand, cand_nxt;
  logic [3:0]       code_nxt;
  logic             valid_nxt, held_nxt;
  logic             match_cand, match_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

  assign cnt_inc    = cnt + CNT_W'(1);
  assign match_cand = result.valid && (result.code == cand);
  assign match_key  = result.valid && (result.code == key_code);

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;

    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (result.valid) begin
            cand_nxt = result.code;
            if (DEBOUNCE == 1) begin
              code_nxt  = result.code;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = CONFIRM;
            end
          end else begin
            cnt_nxt = '0;
          end
        end

        CONFIRM: begin
          if (match_cand) begin
            if (cnt_inc >= DEB_C) begin
              code_nxt  = cand;
              valid_nxt = 1'b1;
              held_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end

        HELD: begin
          if (match_key) begin
            cnt_nxt = '0;
          end else if (DEBOUNCE == 1) begin
            held_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = RELEASE;
          end
        end

        RELEASE: begin
          if (match_key) begin
            cnt_nxt   = '0;
            state_nxt = HELD;
          end else if (cnt_inc >= DEB_C) begin
            held_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end

        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_varredor_teclado.sv
// -----------------------------------------------------------------------------
// tb_varredor_teclado
// Bench for varredor_teclado with DWELL=4, DEBOUNCE=3 (one scan = 16 cycles).
// A keypad model turns the set of pressed keys into row_n from col_n. Stimulus
// pushes the expected key code and cycle of each key_valid pulse into a queue;
// a monitor on the falling edge pops and compares whenever key_valid is high.
// Cycle k after a reset is the interval following the k-th rising edge after
// the edge that sampled rst; a press made at scan start is accepted at the end
// of scan 3 (cycle 47) and the pulse is seen in cycle 48.
// -----------------------------------------------------------------------------
module tb_varredor_teclado;

  localparam int DWELL    = 4;
  localparam int DEBOUNCE = 3;
  localparam int SCAN     = 4 * DWELL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;   // bit index = key code = col*4+row
  int          cyc  = 0;
  int          t0   = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  varredor_teclado #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (col_n[c] == 1'b0) row_n = row_n & ~keys[c*4 +: 4];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: key_valid=1 code %0h, expected no pulse (cycle %0d)",
                 key_code, cyc - t0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_code", key_code, e.code);
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_held", key_held, 1'b1);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t0  = cyc;
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [3:0] code, input int rel_cycle);
    exp_t e;
    e.code = code;
    e.cyc  = t0 + rel_cycle;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [3:0] exp_col;

    // ---- Reset / scan sequence
    keys = '0;
    repeat (2) @(posedge clk);
    do_reset();
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    for (int k = 0; k < 20; k++) begin
      exp_col = ~(4'b0001 << ((k / DWELL) % 4));
      check("scan_col_n", col_n, exp_col);
      check("scan_idle_out", {key_code, key_valid, key_held}, 6'b0);
      @(posedge clk);
      #1;
    end

    // ---- Clean press of key 6, then release
    keys = 16'h0040;
    do_reset();
    expect_pulse(4'h6, 3 * SCAN);
    run_scans(5);
    check("press_held", key_held, 1'b1);
    check("press_code", key_code, 4'h6);
    keys = '0;
    run_scans(3);
    check("press_released", key_held, 1'b0);

    // ---- Bounce: present 2 scans, absent 1, present 3
    keys = 16'h0040;
    do_reset();
    run_scans(2);
    keys = '0;
    run_scans(1);
    check("bounce_not_held", key_held, 1'b0);
    keys = 16'h0040;
    expect_pulse(4'h6, 6 * SCAN);
    run_scans(2);
    check("bounce_still_not_held", key_held, 1'b0);
    run_scans(1);
    check("bounce_held", key_held, 1'b1);

    // ---- Ghost: keys 6 and 9 together, then only 6
    keys = 16'h0240;
    do_reset();
    run_scans(6);
    check("ghost_not_held", key_held, 1'b0);
    keys = 16'h0040;
    expect_pulse(4'h6, 9 * SCAN);
    run_scans(3);
    check("ghost_then_held", key_held, 1'b1);
    check("ghost_then_code", key_code, 4'h6);

    // ---- Release/hold with key F
    keys = 16'h8000;
    do_reset();
    expect_pulse(4'hF, 3 * SCAN);
    run_scans(4);
    check("hold_held", key_held, 1'b1);
    keys = '0;
    run_scans(2);
    check("short_drop_held", key_held, 1'b1);
    keys = 16'h8000;
    run_scans(1);
    check("restored_held", key_held, 1'b1);
    keys = '0;
    run_scans(2);
    check("drop2_held", key_held, 1'b1);
    run_scans(1);
    check("drop3_released", key_held, 1'b0);
    check("drop3_code_kept", key_code, 4'hF);

    // ---- Mid-operation reset during scan 2 of a key-3 press
    keys = 16'h0008;
    run_scans(1);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_code", key_code, 4'hF);
    do_reset();
    check("midrst_col_n", col_n, 4'b1110);
    check("midrst_key_code", key_code, 4'h0);
    check("midrst_key_valid", key_valid, 1'b0);
    check("midrst_key_held", key_held, 1'b0);
    expect_pulse(4'h3, 3 * SCAN);
    run_scans(2);
    check("midrst_not_yet", key_held, 1'b0);
    run_scans(2);
    check("midrst_held", key_held, 1'b1);
    check("midrst_code", key_code, 4'h3);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
